// File: rtl/mul_div_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_div_unit : iterative unsigned multiply/divide, one bit per clock, with
// a single-cycle register-file write-back. Divider built only if MDU_DIV_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module mul_div_unit #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [WIDTH-1:0]  src_a,
   input  logic [WIDTH-1:0]  src_b,
   input  logic [ADDR_W-1:0] dest_add,
   output logic              busy,
   output logic              done,
   output logic              wb_en,
   output logic [ADDR_W-1:0] wb_add,
   output logic [WIDTH-1:0]  wb_data
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [1:0]          op_q;
   logic [ADDR_W-1:0]   dest_q;
   logic [WIDTH-1:0]    opnd_q;
   logic [WIDTH-1:0]    acc_q;
   logic [WIDTH-1:0]    lo_q;
   logic                done_q;
   logic                wb_en_q;
   logic [ADDR_W-1:0]   wb_add_q;
   logic [WIDTH-1:0]    wb_data_q;

   logic [WIDTH-1:0]    acc_d;
   logic [WIDTH-1:0]    lo_d;
   logic [WIDTH-1:0]    result_d;
   logic                wb_en_d;
   logic [WIDTH-1:0]    mul_addend;
   logic [WIDTH:0]      mul_sum;

   // acc holds the product high half / remainder, lo the multiplier / quotient
   always_comb begin
      mul_addend = lo_q[0] ? opnd_q : '0;
      mul_sum    = {1'b0, acc_q} + {1'b0, mul_addend};
   end

`ifdef MDU_DIV_EN
   logic [WIDTH:0] div_shift;
   logic [WIDTH:0] div_diff;
   logic           div_ge;

   always_comb begin
      div_shift = {acc_q, lo_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      // remainder < divisor, so a set top bit of the shifted value always fits
      div_ge    = div_shift[WIDTH] | ~div_diff[WIDTH];
      if (op_q[1]) begin
         acc_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
         lo_d  = {lo_q[WIDTH-2:0], div_ge};
      end else begin
         acc_d = mul_sum[WIDTH:1];
         lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
      result_d = op_q[0] ? acc_d : lo_d;
      wb_en_d  = (dest_q != '0);
   end
`else
   always_comb begin
      acc_d    = mul_sum[WIDTH:1];
      lo_d     = {mul_sum[0], lo_q[WIDTH-1:1]};
      result_d = op_q[1] ? '0 : (op_q[0] ? acc_d : lo_d);
      wb_en_d  = (dest_q != '0) && !op_q[1];
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         dest_q    <= '0;
         opnd_q    <= '0;
         acc_q     <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         wb_en_q   <= 1'b0;
         wb_add_q  <= '0;
         wb_data_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_RUN;
                  cnt_q   <= '0;
                  acc_q   <= '0;
                  op_q    <= op;
                  dest_q  <= dest_add;
                  opnd_q  <= op[1] ? src_b : src_a;
                  lo_q    <= op[1] ? src_a : src_b;
               end
            end
            S_RUN: begin
               acc_q <= acc_d;
               lo_q  <= lo_d;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == C_LAST) begin
                  state_q   <= S_DONE;
                  done_q    <= 1'b1;
                  wb_en_q   <= wb_en_d;
                  wb_add_q  <= dest_q;
                  wb_data_q <= result_d;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               wb_en_q <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               wb_en_q <= 1'b0;
            end
         endcase
      end
   end

   assign busy    = (state_q != S_IDLE);
   assign done    = done_q;
   assign wb_en   = wb_en_q;
   assign wb_add  = wb_add_q;
   assign wb_data = wb_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mul_div_unit : scoreboard bench for mul_div_unit against an arithmetic
// reference model. Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mul_div_unit;

   localparam int WIDTH  = 32;
   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [1:0]        op = '0;
   logic [WIDTH-1:0]  src_a = '0;
   logic [WIDTH-1:0]  src_b = '0;
   logic [ADDR_W-1:0] dest_add = '0;
   logic              busy;
   logic              done;
   logic              wb_en;
   logic [ADDR_W-1:0] wb_add;
   logic [WIDTH-1:0]  wb_data;

   mul_div_unit #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .src_a    (src_a),
      .src_b    (src_b),
      .dest_add (dest_add),
      .busy     (busy),
      .done     (done),
      .wb_en    (wb_en),
      .wb_add   (wb_add),
      .wb_data  (wb_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [WIDTH-1:0]  data;
      logic              en;
      logic [ADDR_W-1:0] add;
      int                due;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic exp_t model(input logic [1:0] o, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b, input logic [ADDR_W-1:0] d,
                                  input int due);
      exp_t        e;
      logic [63:0] p;
      p = 64'(a) * 64'(b);
      case (o)
         2'd0:    e.data = p[31:0];
         2'd1:    e.data = p[63:32];
         2'd2:    e.data = (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: e.data = (b == 0) ? a : a % b;
      endcase
      e.en  = (d != 0);
`ifndef MDU_DIV_EN
      if (o[1]) begin
         e.data = '0;
         e.en   = 1'b0;
      end
`endif
      e.add = d;
      e.due = due;
      return e;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [ADDR_W-1:0] d);
      int n = 0;
      while (busy !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: busy stuck at %b, required 0", busy);
      end
      op       = o;
      src_a    = a;
      src_b    = b;
      dest_add = d;
      start    = 1'b1;
      sb.push_back(model(o, a, b, d, cyc + 1 + WIDTH));
      @(posedge clk);
      #1;
      start = 1'b0;
      check("busy_after_start", 64'(busy), 64'd1);
      @(negedge clk);
   endtask

   // Monitor: pops an expectation whenever the DUT presents a completion.
   bit   prev_done = 1'b0;
   exp_t m_e;
   always @(negedge clk) begin
      if (reset) begin
         prev_done = 1'b0;
      end else begin
         if (prev_done) begin
            check("done_one_cycle", 64'(done), 64'd0);
            check("busy_fall", 64'(busy), 64'd0);
         end
         prev_done = done;
         if (done || wb_en) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: done=%b wb_en=%b with no operation pending", done, wb_en);
            end else begin
               m_e = sb.pop_front();
               check("done", 64'(done), 64'd1);
               check("wb_en", 64'(wb_en), 64'(m_e.en));
               check("wb_add", 64'(wb_add), 64'(m_e.add));
               check("wb_data", 64'(wb_data), 64'(m_e.data));
               check("latency", 64'(cyc), 64'(m_e.due));
            end
         end
      end
   end

   initial begin
      logic [WIDTH-1:0] ra, rb;
      int n;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_wb_en", 64'(wb_en), 64'd0);
      check("rst_wb_add", 64'(wb_add), 64'd0);
      check("rst_wb_data", 64'(wb_data), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // directed cases
      issue(2'd0, 32'd7, 32'd6, 5'd3);
      issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
      issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5);
      issue(2'd2, 32'd100, 32'd7, 5'd6);
      issue(2'd3, 32'd100, 32'd7, 5'd7);
      issue(2'd2, 32'd5, 32'd0, 5'd8);
      issue(2'd3, 32'd5, 32'd0, 5'd9);
      issue(2'd0, 32'd3, 32'd3, 5'd0);

      // start during RUN must be ignored
      issue(2'd0, 32'd11, 32'd13, 5'd10);
      repeat (9) @(negedge clk);
      op = 2'd1; src_a = 32'hDEAD_BEEF; src_b = 32'h1234_5678; dest_add = 5'd20;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;

      // asynchronous reset mid-operation discards it
      issue(2'd2, 32'd1000, 32'd3, 5'd11);
      repeat (14) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("async_rst_busy", 64'(busy), 64'd0);
      check("async_rst_done", 64'(done), 64'd0);
      check("async_rst_wb_en", 64'(wb_en), 64'd0);
      check("async_rst_wb_add", 64'(wb_add), 64'd0);
      check("async_rst_wb_data", 64'(wb_data), 64'd0);
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      issue(2'd3, 32'd1000, 32'd3, 5'd12);

      // randomized traffic
      for (int i = 0; i < 30; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 5))
            0:       rb = '0;
            1:       rb = 32'hFFFF_FFFF;
            2:       rb = 32'($urandom_range(1, 15));
            default: rb = $urandom;
         endcase
         issue(2'($urandom_range(0, 3)), ra, rb, 5'($urandom_range(0, 31)));
      end

      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d operations outstanding, required 0", sb.size());
      end
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
